audio_dac_serializer: RTL

- Codec-facing end of the write handshake. Accepts stereo sample pairs on write/writedata_left/writedata_right, gated by write_ready.
- Buffers the pairs in a small FIFO and shifts them out MSB-first on AUD_DACDAT in WM8731 left-justified format.
- Timing follows AUD_BCLK and AUD_DACLRCK, which the codec drives as master; both are sampled in the CLOCK_50 domain.
- Sits between the sample-processing logic and the AUD_* pins.

---
 rtl/audio_pkg.sv | 13 +
 rtl/sample_fifo.sv | 82 ++++++++
 rtl/audio_dac_serializer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared constants for the audio DAC serializer slice: default channel word
// width, stereo pair width and the serializer state encoding.
package audio_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 24;
  localparam int unsigned PAIR_WIDTH         = 2 * DEFAULT_DATA_WIDTH;

  // Serializer states (plain constants so legacy tools can consume them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO for stereo sample pairs.
// Ports:
//   clk, rst_n   - clock and synchronous active-low reset
//   push_i       - write request (ignored while full)
//   wdata_i      - pair to write
//   pop_i        - read request (ignored while empty)
//   rdata_c      - head-of-queue pair (combinational)
//   full_c       - count equals DEPTH (combinational)
//   empty_c      - count is zero (combinational)
//   count_o      - number of stored entries (registered)
module sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = PAIR_WIDTH,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign push_ok = push_i & ~full_c;
  assign pop_ok  = pop_i & ~empty_c;
  assign rdata_c = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer/count next state; pointers wrap naturally since DEPTH is 2^n.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Codec-facing DAC serializer: buffers stereo pairs and shifts them out
// MSB-first in WM8731 left-justified format, timed by the codec-driven
// AUD_BCLK / AUD_DACLRCK which are sampled in the CLOCK_50 domain.
// Ports:
//   CLOCK_50, reset_n           - system clock, synchronous active-low reset
//   write, writedata_left/right - pair push, accepted when write_ready
//   write_ready                 - FIFO not full (combinational from count)
//   AUD_BCLK, AUD_DACLRCK       - asynchronous codec clocks (LRCK high = left)
//   AUD_DACDAT                  - registered serial data to the codec
//   fifo_count                  - pairs currently buffered
//   underflow, clear_underflow  - sticky empty-frame flag and its clear
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] writedata_left,
  input  logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  write_ready,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic [CNT_W-1:0]      fifo_count,
  output logic                  underflow,
  input  logic                  clear_underflow
);

  localparam int unsigned PAIR_W = 2 * DATA_WIDTH;
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH);

  // ---------------------------------------------------------------------
  // Synchronizers: [0] and [1] form the 2-flop synchronizer, [2] is history.
  // ---------------------------------------------------------------------
  logic [2:0] bclk_sync_q;
  logic [2:0] lrck_sync_q;
  logic [1:0] warm_q;
  logic       sync_ok;
  logic       bclk_fall;
  logic       lrck_rise;
  logic       lrck_fall;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      warm_q      <= '0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  // Edges are ignored until the pipeline holds real pin samples; otherwise
  // a high LRCK at reset release would look like a fresh rising edge.
  assign sync_ok   = (warm_q == 2'd3);
  assign bclk_fall = sync_ok &  bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_rise = sync_ok & ~lrck_sync_q[2] &  lrck_sync_q[1];
  assign lrck_fall = sync_ok &  lrck_sync_q[2] & ~lrck_sync_q[1];

  // ---------------------------------------------------------------------
  // Pair FIFO (left word in the upper half).
  // ---------------------------------------------------------------------
  logic [PAIR_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;

  sample_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (CLOCK_50),
    .rst_n   (reset_n),
    .push_i  (write),
    .wdata_i ({writedata_left, writedata_right}),
    .pop_i   (fifo_pop),
    .rdata_c (fifo_rdata),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count_o (fifo_count)
  );

  assign write_ready = ~fifo_full;

  // ---------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [BIT_W-1:0]      bitcnt_q, bitcnt_d;
  logic                  bits_done_q, bits_done_d;
  logic                  dacdat_q, dacdat_d;
  logic                  underflow_q, underflow_d;

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      bitcnt_q    <= '0;
      bits_done_q <= 1'b0;
      dacdat_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bitcnt_q    <= bitcnt_d;
      bits_done_q <= bits_done_d;
      dacdat_q    <= dacdat_d;
      underflow_q <= underflow_d;
    end
  end

  // LRCK edges take priority over BCLK so a reload always drops leftovers.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    bitcnt_d    = bitcnt_q;
    bits_done_d = bits_done_q;
    fifo_pop    = 1'b0;
    underflow_d = clear_underflow ? 1'b0 : underflow_q;

    if (lrck_rise) begin
      fifo_pop    = ~fifo_empty;
      if (fifo_empty) begin
        shift_d     = '0;
        hold_d      = '0;
        underflow_d = 1'b1;
      end else begin
        shift_d = fifo_rdata[PAIR_W-1 -: DATA_WIDTH];
        hold_d  = fifo_rdata[DATA_WIDTH-1:0];
      end
      bitcnt_d    = BIT_W'(DATA_WIDTH - 1);
      bits_done_d = 1'b0;
      state_d     = ST_LEFT;
    end else if (lrck_fall && (state_q == ST_LEFT)) begin
      shift_d     = hold_q;
      bitcnt_d    = BIT_W'(DATA_WIDTH - 1);
      bits_done_d = 1'b0;
      state_d     = ST_RIGHT;
    end else if (bclk_fall && (state_q != ST_IDLE) && !bits_done_q) begin
      if (bitcnt_q != '0) begin
        shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
        bitcnt_d = bitcnt_q - BIT_W'(1);
      end else begin
        // Last bit has been on the wire for a full BCLK period: pad with 0.
        bits_done_d = 1'b1;
      end
    end

    dacdat_d = (state_d != ST_IDLE) && !bits_done_d && shift_d[DATA_WIDTH-1];
  end

  assign AUD_DACDAT = dacdat_q;
  assign underflow  = underflow_q;

endmodule
